// File: rtl/regfile_pkg.sv
// Shared types for the multiport register file: sweep FSM states and the x0 address.
package regfile_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } sweep_state_e;

    localparam int REGFILE_ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_multiport_if.sv
// Register-file bus: soft clear, ready, one write port and NRD packed read ports.
// master = decode-stage side, slave = register file.
interface regfile_multiport_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic                 clr_req;
    logic                 ready;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [XLEN-1:0]      wdata;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;

    modport master (
        output clr_req, we, waddr, wdata, raddr,
        input  ready, rdata
    );

    modport slave (
        input  clr_req, we, waddr, wdata, raddr,
        output ready, rdata
    );

endinterface

// File: rtl/regfile_sweep_fsm.sv
// Clear-sweep controller: after reset or a soft clear it walks idx 1..NREGS-1,
// emitting a zero-write strobe each cycle, then raises ready.
module regfile_sweep_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr_req,
    output logic          o_ready,
    output logic          o_sweep_we,
    output logic [AW-1:0] o_sweep_addr
);

    localparam logic [AW-1:0] FIRST_IDX = AW'(1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    sweep_state_e  r_state;
    logic [AW-1:0] r_idx;
    logic          r_ready;

    // State, index and ready advance together; a clear request always restarts at idx 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SWEEP;
            r_idx   <= FIRST_IDX;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                SWEEP: begin
                    if (i_clr_req) begin
                        r_idx <= FIRST_IDX;
                    end else if (r_idx == LAST_IDX) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                RUN: begin
                    if (i_clr_req) begin
                        r_state <= SWEEP;
                        r_idx   <= FIRST_IDX;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= SWEEP;
                    r_idx   <= FIRST_IDX;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready      = r_ready;
    assign o_sweep_we   = (r_state == SWEEP);
    assign o_sweep_addr = r_idx;

endmodule

// File: rtl/regfile_multiport.sv
// NRD-read / 1-write register file with hardwired x0 and a hardware clear sweep.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-first forwarding on read ports.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_multiport_if.slave     bus
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] ZERO_A = AW'(REGFILE_ZERO_ADDR);

    logic                      w_ready;
    logic                      w_sweep_we;
    logic [AW-1:0]             w_sweep_addr;
    logic                      w_user_we;
    logic [NRD-1:0][XLEN-1:0]  w_rdata;

    // Storage needs no reset: the sweep zeroes it before ready is ever raised.
    logic [XLEN-1:0] r_mem [NREGS];

    regfile_sweep_fsm #(.NREGS(NREGS)) u_sweep (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr_req    (bus.clr_req),
        .o_ready      (w_ready),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_addr (w_sweep_addr)
    );

    // User writes only land in RUN and never on x0; the sweep owns the port otherwise.
    assign w_user_we = bus.we && w_ready && (bus.waddr != ZERO_A);

    // Write-port mux: sweep zeroing has priority (it is only active while not ready).
    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_mem[w_sweep_addr] <= '0;
        end else if (w_user_we) begin
            r_mem[bus.waddr] <= bus.wdata;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_hit;
        assign w_ra = bus.raddr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign w_hit = w_user_we && (bus.waddr == w_ra);
`else
        assign w_hit = 1'b0;
`endif
        assign w_rdata[i] = (!w_ready || (w_ra == ZERO_A)) ? '0 :
                            w_hit                          ? bus.wdata :
                                                             r_mem[w_ra];
    end

    assign bus.rdata = w_rdata;
    assign bus.ready = w_ready;

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: default 32x32/2-port instance plus a
// 64-bit, 16-entry, 3-port instance.
module tb_regfile_multiport;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    always #5 clk = ~clk;

    regfile_multiport_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifa ();
    regfile_multiport_if #(.XLEN(64), .NREGS(16), .NRD(3)) ifb ();

    regfile_multiport #(.XLEN(32), .NREGS(32), .NRD(2)) u_dut (
        .clk (clk), .rst_n (rst_n), .bus (ifa)
    );
    regfile_multiport #(.XLEN(64), .NREGS(16), .NRD(3)) u_dut2 (
        .clk (clk), .rst_n (rst2_n), .bus (ifb)
    );

    typedef struct {
        string       tag;
        int          src;
        logic [63:0] want;
    } exp_t;

    exp_t sb[$];
    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, act, want);
        end
    endtask

    // src: 0 ready A, 1..2 port A, 10 ready B, 11..13 port B
    function automatic logic [63:0] obs(input int src);
        case (src)
            0:  return 64'(ifa.ready);
            1:  return 64'(ifa.rdata[31:0]);
            2:  return 64'(ifa.rdata[63:32]);
            10: return 64'(ifb.ready);
            11: return ifb.rdata[63:0];
            12: return ifb.rdata[127:64];
            13: return ifb.rdata[191:128];
            default: return '1;
        endcase
    endfunction

    task automatic push(input string tag, input int src, input logic [63:0] want);
        exp_t e;
        e.tag = tag; e.src = src; e.want = want;
        sb.push_back(e);
    endtask

    task automatic drain;
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.src), e.want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rda(input int p, input int a);
        ifa.raddr[p*5 +: 5] = 5'(a);
    endtask

    task automatic rdb(input int p, input int a);
        ifb.raddr[p*4 +: 4] = 4'(a);
    endtask

    task automatic wra(input int a, input logic [31:0] d);
        ifa.we = 1'b1; ifa.waddr = 5'(a); ifa.wdata = d;
    endtask

    // Hold reset for two edges, release 1 time unit after an edge: now in cycle 1.
    task automatic reset_a;
        rst_n = 1'b0;
        ifa.we = 1'b0; ifa.clr_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        ifa.clr_req = 0; ifa.we = 0; ifa.waddr = 0; ifa.wdata = 0; ifa.raddr = 0;
        ifb.clr_req = 0; ifb.we = 0; ifb.waddr = 0; ifb.wdata = 0; ifb.raddr = 0;

        // T1: ready low for 31 cycles, high on cycle 32; reads masked during sweep
        rda(0, 5); rda(1, 31);
        reset_a();
        push("t1_rdy_c1", 0, 0); push("t1_p0_sweep", 1, 0); push("t1_p1_sweep", 2, 0); drain();
        for (int k = 2; k <= 31; k++) begin
            tick(); push("t1_rdy_sweep", 0, 0); push("t1_p1_sweep", 2, 0); drain();
        end
        tick();
        push("t1_rdy_c32", 0, 1); push("t1_p0_zero", 1, 0); push("t1_p1_zero", 2, 0); drain();

        // T2: write x5, read on both ports; x0 writes ignored; top register
        wra(5, 32'hDEADBEEF); tick(); ifa.we = 0;
        rda(0, 5); rda(1, 5);
        push("t2_x5_p0", 1, 32'hDEADBEEF); push("t2_x5_p1", 2, 32'hDEADBEEF); drain();
        wra(0, 32'hFFFFFFFF); rda(0, 0);
        push("t2_x0_same", 1, 0); drain();
        tick(); ifa.we = 0;
        push("t2_x0_after", 1, 0); push("t2_x5_kept", 2, 32'hDEADBEEF); drain();
        wra(31, 32'h31313131); tick(); ifa.we = 0; rda(1, 31);
        push("t2_x31", 2, 32'h31313131); drain();

        // T3: same-cycle write/read of x7
        wra(7, 32'h1111); tick();
        wra(7, 32'h1234); rda(0, 7); rda(1, 6);
        push("t3_same_cyc", 1, BYP ? 64'h1234 : 64'h1111); push("t3_other_port", 2, 0); drain();
        tick(); ifa.we = 0;
        push("t3_next_cyc", 1, 32'h1234); drain();

        // T4: write at cycle 10 of sweep is dropped; everything swept
        reset_a();
        for (int k = 2; k <= 10; k++) tick();
        wra(3, 32'hAA); rda(0, 3); rda(1, 5);
        push("t4_rdy_c10", 0, 0); push("t4_p0_masked", 1, 0); drain();
        tick(); ifa.we = 0;
        for (int k = 12; k <= 31; k++) begin
            tick(); push("t4_rdy_sweep", 0, 0); drain();
        end
        tick();
        push("t4_rdy_c32", 0, 1); push("t4_x3", 1, 0); push("t4_x5_swept", 2, 0); drain();

        // T5: clr_req together with a write in RUN
        wra(9, 32'h55); tick(); ifa.we = 0; rda(0, 9);
        push("t5_x9", 1, 32'h55); drain();
        ifa.clr_req = 1; wra(4, 32'h77); rda(0, 4); rda(1, 9);
        push("t5_rdy_clr", 0, 1); push("t5_x4_same", 1, BYP ? 64'h77 : 64'h0);
        push("t5_x9_same", 2, 32'h55); drain();
        tick(); ifa.clr_req = 0; ifa.we = 0;
        push("t5_rdy_drop", 0, 0); push("t5_x9_masked", 2, 0); drain();
        for (int k = 2; k <= 31; k++) begin
            tick(); push("t5_rdy_sweep", 0, 0); drain();
        end
        tick();
        push("t5_rdy_back", 0, 1); push("t5_x4", 1, 0); push("t5_x9", 2, 0); drain();

        // clr_req mid-sweep restarts the full sweep length
        ifa.clr_req = 1; tick(); ifa.clr_req = 0;
        for (int k = 2; k <= 20; k++) tick();
        ifa.clr_req = 1; tick(); ifa.clr_req = 0;
        push("t7_rdy_restart", 0, 0); drain();
        for (int k = 2; k <= 31; k++) begin
            tick(); push("t7_rdy_sweep", 0, 0); drain();
        end
        tick();
        push("t7_rdy_back", 0, 1); drain();

        // T6: reset pulse at sweep cycle 15 restarts the sweep from release
        reset_a();
        for (int k = 2; k <= 15; k++) tick();
        rst_n = 0; #1;
        push("t6_rdy_in_rst", 0, 0); drain();
        rst_n = 1;
        push("t6_rdy_c1", 0, 0); drain();
        for (int k = 2; k <= 31; k++) begin
            tick(); push("t6_rdy_sweep", 0, 0); drain();
        end
        tick();
        push("t6_rdy_c32", 0, 1); drain();

        // Second configuration: XLEN=64, NREGS=16, NRD=3
        rdb(0, 5); rdb(1, 15); rdb(2, 1);
        tick(); rst2_n = 1;
        push("b1_rdy_c1", 10, 0); push("b1_p1_masked", 12, 0); drain();
        for (int k = 2; k <= 15; k++) begin
            tick(); push("b1_rdy_sweep", 10, 0); drain();
        end
        tick();
        push("b1_rdy_c16", 10, 1); push("b1_p0", 11, 0); push("b1_p1", 12, 0); push("b1_p2", 13, 0);
        drain();
        ifb.we = 1; ifb.waddr = 4'd5; ifb.wdata = 64'hDEADBEEF_CAFEF00D;
        tick(); ifb.we = 0;
        rdb(0, 5); rdb(1, 5); rdb(2, 5);
        push("b2_x5_p0", 11, 64'hDEADBEEF_CAFEF00D); push("b2_x5_p1", 12, 64'hDEADBEEF_CAFEF00D);
        push("b2_x5_p2", 13, 64'hDEADBEEF_CAFEF00D); drain();
        ifb.we = 1; ifb.waddr = 4'd0; ifb.wdata = '1;
        tick();
        ifb.waddr = 4'd15; ifb.wdata = 64'h0123_4567_89AB_CDEF;
        tick(); ifb.we = 0;
        rdb(0, 0); rdb(1, 15);
        push("b2_x0", 11, 0); push("b2_x15", 12, 64'h0123_4567_89AB_CDEF);
        push("b2_x5_kept", 13, 64'hDEADBEEF_CAFEF00D); drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
